// File: rtl/bit_entry_shifter.sv
// -----------------------------------------------------------------------------
// bit_entry_shifter
//   Button-driven bit-entry register for the front panel. Three raw
//   pushbuttons (enter-0, enter-1, clear) are each synchronised, debounced
//   and rising-edge detected. Every accepted bit press shifts one bit into a
//   WIDTH-bit register. Once WIDTH bits are in, valid is raised and held
//   until the consumer pulses ack or the clear button is pressed.
//
// Parameters
//   WIDTH      entry register width (2..16)
//   DB_CYCLES  consecutive stable samples needed to accept a level change
//   MSB_IN     1: new bit enters at WIDTH-1, shift right
//              0: new bit enters at bit 0, shift left
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high
//   btn0        raw "enter 0" button (asynchronous)
//   btn1        raw "enter 1" button (asynchronous)
//   btn_clr     raw "clear" button (asynchronous)
//   ack         consumer accepts the completed word (clk domain)
//   data_out    entry register
//   count       bits entered since the last clear or ack
//   valid       word complete, held until ack or clear
//   bit_strobe  one-cycle pulse alongside each new data_out/count value
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// bit_entry_debounce
//   One button channel: 2-flop synchroniser, counter-based debouncer and a
//   registered rising-edge press pulse.
//
// Ports
//   clk      system clock
//   reset    synchronous, active-high
//   btn_raw  raw asynchronous button level
//   press    one-cycle pulse on each accepted rising edge of the level
// -----------------------------------------------------------------------------
module bit_entry_debounce #(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned CW = $clog2(DB_CYCLES + 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          stable_q, stable_d;
    logic          stable_dly_q, stable_dly_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d         = btn_raw;
        s2_d         = s1_q;
        stable_d     = stable_q;
        cnt_d        = '0;
        stable_dly_d = stable_q;

        // Counting cycles of disagreement; any agreeing cycle leaves cnt_d
        // at zero, so bounce restarts the count. Comparing against
        // DB_CYCLES-1 makes the level flip on the cycle the count would
        // reach DB_CYCLES.
        if (s2_q != stable_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                stable_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        press_d = stable_q & ~stable_dly_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            press_q      <= press_d;
            cnt_q        <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

module bit_entry_shifter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned MSB_IN    = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       btn0,
    input  logic                       btn1,
    input  logic                       btn_clr,
    input  logic                       ack,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(WIDTH+1)-1:0] count,
    output logic                       valid,
    output logic                       bit_strobe
);

    localparam int unsigned CNTW = $clog2(WIDTH + 1);

    generate
        if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
            $error("bit_entry_shifter: WIDTH must be in 2..16");
        end
        if (DB_CYCLES < 1 || DB_CYCLES > 65535) begin : g_bad_db
            $error("bit_entry_shifter: DB_CYCLES must be in 1..65535");
        end
    endgenerate

    typedef enum logic {
        ENTRY = 1'b0,
        FULL  = 1'b1
    } state_t;

    logic press0, press1, press_clr;

    bit_entry_debounce #(.DB_CYCLES(DB_CYCLES)) u_db0 (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn0),
        .press   (press0)
    );

    bit_entry_debounce #(.DB_CYCLES(DB_CYCLES)) u_db1 (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn1),
        .press   (press1)
    );

    bit_entry_debounce #(.DB_CYCLES(DB_CYCLES)) u_dbc (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_clr),
        .press   (press_clr)
    );

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic              valid_q, valid_d;
    logic              strobe_q, strobe_d;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        count_d  = count_q;
        strobe_d = 1'b0;

        // Priority: clear, conflicting bit presses, ack, single bit press.
        if (press_clr) begin
            state_d = ENTRY;
            data_d  = '0;
            count_d = '0;
        end else if (press0 && press1) begin
            // Ambiguous entry: drop both.
        end else if (ack && state_q == FULL) begin
            state_d = ENTRY;
            count_d = '0;
        end else if ((press0 || press1) && state_q == ENTRY) begin
            // press1 alone means the bit is 1; press0 alone means 0.
            if (MSB_IN != 0) begin
                data_d = {press1, data_q[WIDTH-1:1]};
            end else begin
                data_d = {data_q[WIDTH-2:0], press1};
            end
            count_d  = count_q + 1'b1;
            strobe_d = 1'b1;
            if (count_q == CNTW'(WIDTH - 1)) begin
                state_d = FULL;
            end
        end

        valid_d = (state_d == FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ENTRY;
            data_q   <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            strobe_q <= strobe_d;
        end
    end

    assign data_out   = data_q;
    assign count      = count_q;
    assign valid      = valid_q;
    assign bit_strobe = strobe_q;

endmodule

// File: tb/tb_bit_entry_shifter.sv
module tb_bit_entry_shifter;

    localparam int DB  = 4;
    // Drive at a negedge with cyc=N; update observed at the negedge with cyc=N+DB+4.
    localparam int LAT = DB + 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic reset;
    logic a_btn0, a_btn1, a_clr, a_ack;
    logic [3:0] a_data;
    logic [2:0] a_count;
    logic a_valid, a_strobe;

    logic b_btn0, b_btn1, b_clr, b_ack;
    logic [7:0] b_data;
    logic [3:0] b_count;
    logic b_valid, b_strobe;

    bit_entry_shifter #(.WIDTH(4), .DB_CYCLES(DB), .MSB_IN(1)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .btn0       (a_btn0),
        .btn1       (a_btn1),
        .btn_clr    (a_clr),
        .ack        (a_ack),
        .data_out   (a_data),
        .count      (a_count),
        .valid      (a_valid),
        .bit_strobe (a_strobe)
    );

    bit_entry_shifter #(.WIDTH(8), .DB_CYCLES(DB), .MSB_IN(0)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .btn0       (b_btn0),
        .btn1       (b_btn1),
        .btn_clr    (b_clr),
        .ack        (b_ack),
        .data_out   (b_data),
        .count      (b_count),
        .valid      (b_valid),
        .bit_strobe (b_strobe)
    );

    typedef struct {
        logic [15:0] data;
        logic [7:0]  count;
        logic        valid;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    int checks = 0;
    int errors = 0;
    int base   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitors: every bit_strobe pops and compares one expectation.
    always @(negedge clk) begin
        if (a_strobe === 1'b1) begin
            if (qa.size() == 0) begin
                check("a_unexpected_strobe", 32'(a_strobe), 32'd0);
            end else begin
                ea = qa.pop_front();
                check("a_data",   32'(a_data),  32'(ea.data));
                check("a_count",  32'(a_count), 32'(ea.count));
                check("a_valid",  32'(a_valid), 32'(ea.valid));
                check("a_timing", 32'(cyc),     32'(ea.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (b_strobe === 1'b1) begin
            if (qb.size() == 0) begin
                check("b_unexpected_strobe", 32'(b_strobe), 32'd0);
            end else begin
                eb = qb.pop_front();
                check("b_data",   32'(b_data),  32'(eb.data));
                check("b_count",  32'(b_count), 32'(eb.count));
                check("b_valid",  32'(b_valid), 32'(eb.valid));
                check("b_timing", 32'(cyc),     32'(eb.cyc));
            end
        end
    end

    task automatic drive_a(input logic b0, input logic b1, input logic bc);
        @(negedge clk);
        a_btn0 = b0;
        a_btn1 = b1;
        a_clr  = bc;
        base   = cyc;
    endtask

    task automatic release_a();
        repeat (12) @(negedge clk);
        a_btn0 = 1'b0;
        a_btn1 = 1'b0;
        a_clr  = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic push_a(input logic [3:0] d, input int c, input logic v);
        qa.push_back('{data: 16'(d), count: 8'(c), valid: v, cyc: base + LAT});
    endtask

    task automatic press_a(input logic b, input logic [3:0] d, input int c, input logic v);
        drive_a(~b, b, 1'b0);
        push_a(d, c, v);
        release_a();
    endtask

    task automatic press_b(input logic b, input logic [7:0] d, input int c);
        @(negedge clk);
        b_btn0 = ~b;
        b_btn1 = b;
        qb.push_back('{data: 16'(d), count: 8'(c), valid: 1'b0, cyc: cyc + LAT});
        repeat (12) @(negedge clk);
        b_btn0 = 1'b0;
        b_btn1 = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic check_a(input string tag, input logic [3:0] d, input int c, input logic v);
        check({tag, "_data"},  32'(a_data),  32'(d));
        check({tag, "_count"}, 32'(a_count), 32'(c));
        check({tag, "_valid"}, 32'(a_valid), 32'(v));
    endtask

    initial begin
        reset  = 1'b1;
        a_btn0 = 1'b0; a_btn1 = 1'b0; a_clr = 1'b0; a_ack = 1'b0;
        b_btn0 = 1'b0; b_btn1 = 1'b0; b_clr = 1'b0; b_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_a("reset", 4'b0000, 0, 1'b0);
        check("reset_strobe", 32'(a_strobe), 32'd0);
        check("reset_b_data", 32'(b_data), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Clean presses 1,0,1,1.
        press_a(1'b1, 4'b1000, 1, 1'b0);
        press_a(1'b0, 4'b0100, 2, 1'b0);
        press_a(1'b1, 4'b1010, 3, 1'b0);
        press_a(1'b1, 4'b1101, 4, 1'b1);

        // Bit press while FULL is discarded.
        drive_a(1'b1, 1'b0, 1'b0);
        release_a();
        check_a("full_press", 4'b1101, 4, 1'b1);

        // Ack: valid and count drop, data held.
        @(negedge clk);
        a_ack = 1'b1;
        @(negedge clk);
        a_ack = 1'b0;
        check_a("ack", 4'b1101, 0, 1'b0);

        press_a(1'b0, 4'b0110, 1, 1'b0);

        // Bounce on btn1: high 3, low 1, then high and held.
        @(negedge clk);
        a_btn1 = 1'b1;
        repeat (3) @(negedge clk);
        a_btn1 = 1'b0;
        @(negedge clk);
        a_btn1 = 1'b1;
        base = cyc;
        push_a(4'b1011, 2, 1'b0);
        release_a();
        check_a("bounce", 4'b1011, 2, 1'b0);

        // btn0 and btn1 together: no change.
        drive_a(1'b1, 1'b1, 1'b0);
        release_a();
        check_a("both_bits", 4'b1011, 2, 1'b0);

        // Clear together with btn1: cleared, no strobe.
        drive_a(1'b0, 1'b1, 1'b1);
        release_a();
        check_a("clr_btn1", 4'b0000, 0, 1'b0);

        // Fill, then ack coincident with a btn0 press pulse.
        press_a(1'b1, 4'b1000, 1, 1'b0);
        press_a(1'b1, 4'b1100, 2, 1'b0);
        press_a(1'b1, 4'b1110, 3, 1'b0);
        press_a(1'b1, 4'b1111, 4, 1'b1);
        drive_a(1'b1, 1'b0, 1'b0);
        repeat (LAT - 1) @(negedge clk);
        a_ack = 1'b1;
        @(negedge clk);
        a_ack = 1'b0;
        check_a("ack_btn0", 4'b1111, 0, 1'b0);
        check("ack_btn0_strobe", 32'(a_strobe), 32'd0);
        release_a();
        check_a("ack_btn0_after", 4'b1111, 0, 1'b0);

        // Reset mid-debounce.
        drive_a(1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        reset  = 1'b1;
        a_btn1 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_a("mid_reset", 4'b0000, 0, 1'b0);
        check("mid_reset_strobe", 32'(a_strobe), 32'd0);
        repeat (20) @(negedge clk);
        check_a("mid_reset_after", 4'b0000, 0, 1'b0);

        // btn1 held across reset release: exactly one shift.
        @(negedge clk);
        reset  = 1'b1;
        a_btn1 = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        base  = cyc;
        push_a(4'b1000, 1, 1'b0);
        repeat (20) @(negedge clk);
        a_btn1 = 1'b0;
        repeat (12) @(negedge clk);
        check_a("held_reset", 4'b1000, 1, 1'b0);

        // WIDTH=8, LSB entry: 1,1,0.
        press_b(1'b1, 8'b0000_0001, 1);
        press_b(1'b1, 8'b0000_0011, 2);
        press_b(1'b0, 8'b0000_0110, 3);
        check("b_final_data",  32'(b_data),  32'h06);
        check("b_final_count", 32'(b_count), 32'd3);
        check("b_final_valid", 32'(b_valid), 32'd0);

        repeat (4) @(negedge clk);
        check("a_queue_left", 32'(qa.size()), 32'd0);
        check("b_queue_left", 32'(qb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_entry_shifter.md
# bit_entry_shifter

Parametrised button-driven bit-entry register for the board front panel. It takes three raw pushbuttons: bit-0, bit-1 and clear. Each button is synchronised, debounced and edge-detected, and each accepted press shifts one bit into a WIDTH-bit register. When WIDTH bits have been entered, the block raises a valid/ack handshake so downstream display or setting logic can consume the completed word.

## Interface
- WIDTH, default 4: entry register width; legal range 2..16.
- DB_CYCLES, default 16: consecutive stable samples needed to accept a level change; legal range 1..65535.
- MSB_IN, default 1: entry direction.
  - 1: new bit enters at bit WIDTH-1 and the register shifts right.
  - 0: new bit enters at bit 0 and the register shifts left.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- btn0  in  1  raw "enter 0" button, asynchronous.
- btn1  in  1  raw "enter 1" button, asynchronous.
- btn_clr  in  1  raw "clear" button, asynchronous.
- ack  in  1  consumer accepts the completed word; only meaningful while valid=1.
- data_out  out  WIDTH  entry register.
- count  out  $clog2(WIDTH+1)  number of bits entered since the last clear or ack.
- valid  out  1  word complete; stays high until ack or clear.
- bit_strobe  out  1  one-cycle pulse, high in the same cycle the new data_out/count first appear.

## Operation
- Per-button front end; the three channels are identical and independent.
  - Synchronise through 2 flops, s1 then s2.
  - Hold a debounced level `stable` and a counter of $clog2(DB_CYCLES+1) bits.
  - While s2 != stable, the counter increments each cycle. When it reaches DB_CYCLES, `stable` takes s2 and the counter clears.
  - Any cycle with s2 == stable clears the counter, so bounce restarts the count.
  - A rising edge of `stable` produces a registered one-cycle press pulse. Falling edges produce nothing.
- Press resolution each cycle, highest priority first:
  - clr press: data_out=0, count=0, valid=0. No bit_strobe. Any same-cycle bit press or ack is discarded.
  - bit0 and bit1 pressed in the same cycle: both discarded, no change.
  - ack while valid=1: valid=0, count=0, data_out held. A same-cycle bit press is discarded.
  - A single bit press when valid=0: shift in per MSB_IN, count+1, bit_strobe=1. If count becomes WIDTH, valid=1 in the same update.
  - A bit press while valid=1: discarded, no state change.
- ack while valid=0 is ignored.
- Two states: ENTRY (valid=0) and FULL (valid=1).
  - ENTRY -> FULL on the WIDTH-th accepted bit.
  - FULL -> ENTRY on ack or clear.
  - ENTRY -> ENTRY on clear.
- count never exceeds WIDTH and never wraps.

## Timing
- All outputs and internal flops reset to 0 (s1, s2, stable, counters, press pulses, data_out, count, valid, bit_strobe).
- Press latency, with edge 0 being the first clk edge that samples a clean high on the button:
  - s2=1 at edge 1.
  - stable=1 at edge DB_CYCLES+1.
  - press pulse at edge DB_CYCLES+2.
  - data_out, count, valid and bit_strobe update at edge DB_CYCLES+3.
- Release is debounced with the same DB_CYCLES rule. A new press is accepted only after a release has been accepted.
- ack is not synchronised (clk-domain source). Its effect is visible one edge later.
- Reset mid-debounce aborts the count; no press is produced from pre-reset samples.
- A button held high across reset release registers exactly one press, DB_CYCLES+3 edges after the first post-reset sampling edge.

## Test plan
- WIDTH=4, DB_CYCLES=4, MSB_IN=1; clean presses 1,0,1,1:
  - data_out = 1000, 0100, 1010, 1101.
  - count = 1, 2, 3, 4.
  - valid=1 together with the 4th bit_strobe.
  - Each update occurs exactly 7 edges after its sampling edge 0.
- Bounce: btn1 pulses high for 3 cycles, low for 1, high for 3, then stays high. Required: exactly one shift, with latency measured from the final rising sample.
- Full and ack: from 1101/valid=1, press btn0 → no change. Assert ack → valid=0, count=0, data held at 1101. Press btn0 → 0110, count=1.
- Simultaneous events:
  - btn0 and btn1 accepted in the same cycle → no change.
  - clr together with btn1 → data_out=0, count=0, no bit_strobe.
  - ack together with btn0 in FULL → ack only.
- WIDTH=8, MSB_IN=0; presses 1,1,0 → data_out=00000110, count=3, valid=0.
- Reset: assert reset mid-debounce → all outputs 0 and no press produced. Hold btn1 across reset release → exactly one shift, at edge DB_CYCLES+3.
